// File: rtl/imem_loader_resp.sv
// rtl/imem_loader_resp.sv - instruction memory responder with byte-stream boot loader
// Serves registered word fetches in RUN; fills memory from a byte stream in LOAD, then pulses start.
module imem_loader_resp #(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000,
  parameter logic [31:0] NOP  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  input  logic        mem_cs,
  output logic [31:0] insr_mem,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        start,
  output logic        ld_err
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD,
    S_LAUNCH
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    insr_q, insr_d;
  logic [31:0]    asm_q, asm_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           err_q, err_d;

  logic [31:0]    mem [DEPTH];
  logic           we;
  logic [31:0]    merged;
  logic           in_range;
  logic [AW-1:0]  rd_idx;
  logic           accept;
  logic           unused_pc;

  assign in_range  = (PC[31:AW+2] == BASE[31:AW+2]);
  assign rd_idx    = PC[AW+1:2];
  assign unused_pc = ^PC[1:0];
  assign accept    = ld_valid && (state_q == S_LOAD);

  // Current byte dropped into its lane; upper lanes stay zero because asm is cleared per word.
  always_comb begin
    merged = asm_q;
    merged[{cnt_q, 3'b000} +: 8] = ld_data;
  end

  always_comb begin
    state_d = state_q;
    insr_d  = insr_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    we      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_cs) begin
          insr_d = in_range ? mem[rd_idx] : NOP;
        end
        if (ld_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          asm_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (mem_cs) begin
          insr_d = NOP;
        end
        if (accept) begin
          // After overflow, bytes are still handshaken but go nowhere.
          if (!err_q) begin
            if (cnt_q == 2'd3 || ld_last) begin
              we    = 1'b1;
              asm_d = '0;
              cnt_d = '0;
              if (&ptr_q) begin
                err_d = 1'b1;
              end else begin
                ptr_d = ptr_q + AW'(1);
              end
            end else begin
              asm_d = merged;
              cnt_d = cnt_q + 2'd1;
            end
          end
          if (ld_last) begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (mem_cs) begin
          insr_d = NOP;
        end
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      insr_q  <= NOP;
      asm_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      insr_q  <= insr_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_q] <= merged;
    end
  end

  assign insr_mem = insr_q;
  assign ld_ready = (state_q == S_LOAD);
  assign start    = (state_q == S_LAUNCH);
  assign ld_err   = err_q;

endmodule

// File: tb/tb_imem_loader_resp.sv
// tb/tb_imem_loader_resp.sv - randomized self-checking bench for imem_loader_resp
// Drives an AW=10 and an AW=2 instance in parallel against a word-level memory model.
module tb_imem_loader_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] PC;
  logic        mem_cs;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic [31:0] insr_a, insr_b;
  logic        ready_a, ready_b, start_a, start_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m10 [1024];
  bit          w10 [1024];
  logic [31:0] m2  [4];
  bit          w2  [4];
  logic [7:0]  sess_q [$];

  imem_loader_resp #(.AW(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .PC(PC), .mem_cs(mem_cs), .insr_mem(insr_a),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ready_a), .start(start_a), .ld_err(err_a)
  );

  imem_loader_resp #(.AW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .PC(PC), .mem_cs(mem_cs), .insr_mem(insr_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ready_b), .start(start_b), .ld_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expv(input logic [31:0] pc, input int aw);
    logic [31:0] idx;
    if ((pc >> (aw + 2)) != 0) return NOP;
    idx = (pc >> 2) & ((32'd1 << aw) - 1);
    if (aw == 10) return m10[idx[9:0]];
    return m2[idx[1:0]];
  endfunction

  function automatic bit known(input logic [31:0] pc, input int aw);
    logic [31:0] idx;
    if ((pc >> (aw + 2)) != 0) return 1'b1;
    idx = (pc >> 2) & ((32'd1 << aw) - 1);
    if (aw == 10) return w10[idx[9:0]];
    return w2[idx[1:0]];
  endfunction

  // Words the stream produces: little-endian groups of four bytes, zero padded.
  task automatic apply_model(input int n, input bit complete);
    int nw;
    logic [31:0] word;
    nw = complete ? (n + 3) / 4 : n / 4;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < n) word[8*l +: 8] = sess_q[4*w+l];
      end
      if (w < 1024) begin m10[w] = word; w10[w] = 1'b1; end
      if (w < 4)    begin m2[w]  = word; w2[w]  = 1'b1; end
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    logic [31:0] e10, e2;
    bit k10, k2;
    e10 = expv(pc, 10); k10 = known(pc, 10);
    e2  = expv(pc, 2);  k2  = known(pc, 2);
    PC = pc; mem_cs = 1'b1;
    tick();
    mem_cs = 1'b0;
    if (k10) begin
      n_cmp++;
      if (insr_a !== e10) begin n_bad++; $display("FAIL fetch_a pc=%h got=%h exp=%h", pc, insr_a, e10); end
    end
    if (k2) begin
      n_cmp++;
      if (insr_b !== e2) begin n_bad++; $display("FAIL fetch_b pc=%h got=%h exp=%h", pc, insr_b, e2); end
    end
  endtask

  task automatic run_session(input int stall_max, input bit fetch_in_load,
                             input bit fetch_on_start, input logic [31:0] start_pc);
    int n;
    int stalls;
    logic [31:0] e10, e2;
    bit k10, k2;
    bit exp_e10, exp_e2;
    n = sess_q.size();
    e10 = expv(start_pc, 10); k10 = known(start_pc, 10);
    e2  = expv(start_pc, 2);  k2  = known(start_pc, 2);
    PC = start_pc; mem_cs = fetch_on_start; ld_start = 1'b1;
    tick();
    ld_start = 1'b0; mem_cs = 1'b0;
    n_cmp++;
    if ({ready_a, ready_b, err_a, err_b} !== 4'b1100) begin
      n_bad++; $display("FAIL load_entry ready/err got=%b exp=1100", {ready_a, ready_b, err_a, err_b});
    end
    if (fetch_on_start && k10 && k2) begin
      n_cmp++;
      if ({insr_a, insr_b} !== {e10, e2}) begin
        n_bad++; $display("FAIL fetch_with_start got=%h/%h exp=%h/%h", insr_a, insr_b, e10, e2);
      end
    end
    for (int i = 0; i < n; i++) begin
      stalls = $urandom_range(stall_max, 0);
      for (int s = 0; s < stalls; s++) begin
        ld_valid = 1'b0; mem_cs = fetch_in_load; PC = $urandom;
        tick();
        mem_cs = 1'b0;
        if (fetch_in_load) begin
          n_cmp++;
          if ({insr_a, insr_b} !== {NOP, NOP}) begin
            n_bad++; $display("FAIL blocked_fetch got=%h/%h exp=%h", insr_a, insr_b, NOP);
          end
        end
      end
      ld_valid = 1'b1; ld_data = sess_q[i]; ld_last = (i == n - 1);
      tick();
      ld_valid = 1'b0; ld_last = 1'b0;
    end
    n_cmp++;
    if ({start_a, start_b, ready_a, ready_b} !== 4'b1100) begin
      n_bad++; $display("FAIL launch start/ready got=%b exp=1100", {start_a, start_b, ready_a, ready_b});
    end
    tick();
    n_cmp++;
    if ({start_a, start_b} !== 2'b00) begin
      n_bad++; $display("FAIL start_width got=%b exp=00", {start_a, start_b});
    end
    apply_model(n, 1'b1);
    exp_e10 = ((n + 3) / 4) >= 1024;
    exp_e2  = ((n + 3) / 4) >= 4;
    n_cmp++;
    if ({err_a, err_b} !== {exp_e10, exp_e2}) begin
      n_bad++; $display("FAIL ld_err got=%b exp=%b", {err_a, err_b}, {exp_e10, exp_e2});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({insr_a, insr_b} !== {NOP, NOP}) begin
      n_bad++; $display("FAIL reset_insr got=%h/%h exp=%h", insr_a, insr_b, NOP);
    end
    n_cmp++;
    if ({ready_a, ready_b, start_a, start_b, err_a, err_b} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=000000", {ready_a, ready_b, start_a, start_b, err_a, err_b});
    end
  endtask

  task automatic test_load_basic();
    sess_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    run_session(0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h0);
    n_cmp++;
    if (insr_a !== 32'h00A00513) begin n_bad++; $display("FAIL word0 got=%h exp=00a00513", insr_a); end
    do_fetch(32'h4);
    do_fetch(32'h6);
    n_cmp++;
    if (insr_a !== 32'h00B00593) begin n_bad++; $display("FAIL word1_pc6 got=%h exp=00b00593", insr_a); end
  endtask

  task automatic test_partial();
    sess_q = {};
    for (int i = 0; i < 4; i++) sess_q.push_back(8'($urandom));
    sess_q.push_back(8'h37);
    run_session(1, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h4);
    n_cmp++;
    if (insr_a !== 32'h00000037) begin n_bad++; $display("FAIL partial_word got=%h exp=00000037", insr_a); end
    do_fetch(32'h0);
  endtask

  task automatic test_random_load();
    sess_q = {};
    for (int i = 0; i < 256; i++) sess_q.push_back(8'($urandom));
    run_session(2, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h000000F8);
    PC = 32'h0; mem_cs = 1'b0;
    tick();
    n_cmp++;
    if (insr_a !== m10[62]) begin n_bad++; $display("FAIL hold got=%h exp=%h", insr_a, m10[62]); end
    do_fetch(32'h00001000);
    n_cmp++;
    if (insr_a !== NOP) begin n_bad++; $display("FAIL out_of_range got=%h exp=%h", insr_a, NOP); end
    for (int i = 0; i < 40; i++) do_fetch($urandom_range(32'h11FF, 0));
  endtask

  task automatic test_stall();
    sess_q = {};
    for (int i = 0; i < 7; i++) sess_q.push_back(8'($urandom));
    run_session(5, 1'b1, 1'b0, 32'h0);
    do_fetch(32'h0);
    do_fetch(32'h4);
  endtask

  task automatic test_overflow();
    sess_q = {};
    for (int i = 0; i < 20; i++) sess_q.push_back(8'($urandom));
    run_session(1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) do_fetch(32'(4 * i));
    sess_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_session(0, 1'b0, 1'b1, 32'h8);
    do_fetch(32'h0);
  endtask

  task automatic test_reset_midload();
    sess_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h55, 8'h66};
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_data = sess_q[i];
      tick();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({ready_a, ready_b, start_a, start_b} !== 4'b0) begin
      n_bad++; $display("FAIL midload_reset got=%b exp=0000", {ready_a, ready_b, start_a, start_b});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({start_a, start_b} !== 2'b00) begin n_bad++; $display("FAIL no_start got=%b exp=00", {start_a, start_b}); end
    end
    apply_model(6, 1'b0);
    do_fetch(32'h0);
    n_cmp++;
    if (insr_a !== 32'hDEADBEEF) begin n_bad++; $display("FAIL retained_word got=%h exp=deadbeef", insr_a); end
  endtask

  initial begin
    rst_n = 1'b0; PC = '0; mem_cs = 1'b0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    test_reset();
    test_load_basic();
    test_partial();
    test_random_load();
    test_stall();
    test_overflow();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
